// File: rtl/tx9_lane_framer.sv
// ---------------------------------------------------------------------------
// tx9_lane_framer
//   Source stage for the 9-lane LVDS transmitter. It accepts an 80-bit
//   valid/ready payload stream and produces nine registered 10-bit lane words
//   per cycle. Lanes 0-7 carry payload slices and lane 8 carries a control word
//   {type[1:0], seq[3:0], 4-bit parity field}. After every PLL lock the block
//   sends TRAIN_PATTERN on all nine lanes for TRAIN_CYCLES cycles. Only after
//   that does it accept data, so the receiver can word-align.
//
//   Optional feature macro: TX9_LANE_PARITY_EN
//     defined   -> data words carry even parity of the payload in o8_p[0]
//     undefined -> o8_p[3:0] is always 4'b0000 and no parity logic is built
//
// Ports
//   I_clk        in   1   transmitter core clock
//   I_rst_n      in   1   asynchronous active-low reset
//   I_tx_locked  in   1   PLL lock (asynchronous, 2-flop synchronised here)
//   I_data       in   80  payload word
//   I_valid      in   1   I_data valid
//   O_ready      out  1   block accepts I_data this cycle
//   o0_p..o7_p   out  10  data lane words, o<k>_p = payload[10k+9:10k]
//   o8_p         out  10  control lane word
//   O_link_up    out  1   high while the framer is in RUN
// ---------------------------------------------------------------------------
module tx9_lane_framer #(
    parameter int unsigned TRAIN_CYCLES  = 256,
    parameter logic [9:0]  TRAIN_PATTERN = 10'h3E0,
    parameter logic [9:0]  IDLE_DATA     = 10'h000
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_tx_locked,
    input  logic [79:0] I_data,
    input  logic        I_valid,
    output logic        O_ready,
    output logic [9:0]  o0_p,
    output logic [9:0]  o1_p,
    output logic [9:0]  o2_p,
    output logic [9:0]  o3_p,
    output logic [9:0]  o4_p,
    output logic [9:0]  o5_p,
    output logic [9:0]  o6_p,
    output logic [9:0]  o7_p,
    output logic [9:0]  o8_p,
    output logic        O_link_up
);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'b00,
        ST_TRAIN     = 2'b01,
        ST_RUN       = 2'b10
    } state_t;

    localparam logic [15:0] TRAIN_LOAD = 16'(TRAIN_CYCLES - 32'd1);

`ifdef TX9_LANE_PARITY_EN
    // Even parity over the full 80-bit payload.
    function automatic logic parity80(input logic [79:0] d);
        return ^d;
    endfunction
`endif

    // Low nibble of the control word for a data word.
    function automatic logic [3:0] ctrl_low(input logic [79:0] d);
`ifdef TX9_LANE_PARITY_EN
        return {3'b000, parity80(d)};
`else
        return 4'b0000;
`endif
    endfunction

    logic [1:0]  lock_sync_r;
    logic        lock_s;
    state_t      state_r, state_nxt_s;
    logic [15:0] train_cnt_r, train_cnt_nxt_s;
    logic [3:0]  seq_r, seq_nxt_s;
    logic [79:0] fifo_mem_r [2];
    logic [79:0] fifo_mem_nxt_s [2];
    logic [1:0]  count_r, count_nxt_s;
    logic [9:0]  lane_r [8];
    logic [9:0]  lane_nxt_s [8];
    logic [9:0]  ctrl_r, ctrl_nxt_s;
    logic        ready_r, link_r;
    logic        push_s;
    logic        have_word_s;
    logic [79:0] word_s;

    assign lock_s = lock_sync_r[1];
    // A handshake during a lock-loss cycle is accepted but its word is dropped.
    assign push_s = I_valid & ready_r & lock_s;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            lock_sync_r <= 2'b00;
        end else begin
            lock_sync_r <= {lock_sync_r[0], I_tx_locked};
        end
    end

    // FSM next-state and training counter; lock loss overrides everything.
    always_comb begin
        state_nxt_s     = state_r;
        train_cnt_nxt_s = train_cnt_r;
        if (!lock_s) begin
            state_nxt_s     = ST_WAIT_LOCK;
            train_cnt_nxt_s = 16'd0;
        end else begin
            case (state_r)
                ST_WAIT_LOCK: begin
                    state_nxt_s     = ST_TRAIN;
                    train_cnt_nxt_s = TRAIN_LOAD;
                end
                ST_TRAIN: begin
                    if (train_cnt_r == 16'd0) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        train_cnt_nxt_s = train_cnt_r - 16'd1;
                    end
                end
                ST_RUN: begin
                    state_nxt_s = ST_RUN;
                end
                default: begin
                    state_nxt_s     = ST_WAIT_LOCK;
                    train_cnt_nxt_s = 16'd0;
                end
            endcase
        end
    end

    // FIFO update and next lane words. A push into an empty FIFO bypasses
    // storage so the word reaches the lanes on the following cycle.
    always_comb begin
        fifo_mem_nxt_s[0] = fifo_mem_r[0];
        fifo_mem_nxt_s[1] = fifo_mem_r[1];
        count_nxt_s       = count_r;
        seq_nxt_s         = seq_r;
        have_word_s       = 1'b0;
        word_s            = 80'd0;
        ctrl_nxt_s        = 10'h000;
        for (int k = 0; k < 8; k++) begin
            lane_nxt_s[k] = 10'h000;
        end

        if (!lock_s) begin
            count_nxt_s = 2'd0;
            seq_nxt_s   = 4'd0;
        end else if (state_r == ST_TRAIN) begin
            count_nxt_s = 2'd0;
            ctrl_nxt_s  = TRAIN_PATTERN;
            for (int k = 0; k < 8; k++) begin
                lane_nxt_s[k] = TRAIN_PATTERN;
            end
        end else if (state_r == ST_RUN) begin
            case (count_r)
                2'd0: begin
                    if (push_s) begin
                        have_word_s = 1'b1;
                        word_s      = I_data;
                    end else begin
                        have_word_s = 1'b0;
                    end
                end
                2'd1: begin
                    have_word_s = 1'b1;
                    word_s      = fifo_mem_r[0];
                    if (push_s) begin
                        fifo_mem_nxt_s[0] = I_data;
                    end else begin
                        count_nxt_s = 2'd0;
                    end
                end
                2'd2: begin
                    have_word_s       = 1'b1;
                    word_s            = fifo_mem_r[0];
                    fifo_mem_nxt_s[0] = fifo_mem_r[1];
                    if (push_s) begin
                        fifo_mem_nxt_s[1] = I_data;
                    end else begin
                        count_nxt_s = 2'd1;
                    end
                end
                default: begin
                    count_nxt_s = 2'd0;
                end
            endcase

            if (have_word_s) begin
                for (int k = 0; k < 8; k++) begin
                    lane_nxt_s[k] = word_s[10*k +: 10];
                end
                ctrl_nxt_s = {2'b01, seq_r, ctrl_low(word_s)};
                seq_nxt_s  = seq_r + 4'd1;
            end else begin
                for (int k = 0; k < 8; k++) begin
                    lane_nxt_s[k] = IDLE_DATA;
                end
                ctrl_nxt_s = {2'b00, seq_r, 4'b0000};
            end
        end else begin
            count_nxt_s = 2'd0;
        end
    end

    // State, counters, FIFO storage and registered outputs.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_r       <= ST_WAIT_LOCK;
            train_cnt_r   <= 16'd0;
            seq_r         <= 4'd0;
            count_r       <= 2'd0;
            fifo_mem_r[0] <= 80'd0;
            fifo_mem_r[1] <= 80'd0;
            ctrl_r        <= 10'h000;
            ready_r       <= 1'b0;
            link_r        <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                lane_r[k] <= 10'h000;
            end
        end else begin
            state_r       <= state_nxt_s;
            train_cnt_r   <= train_cnt_nxt_s;
            seq_r         <= seq_nxt_s;
            count_r       <= count_nxt_s;
            fifo_mem_r[0] <= fifo_mem_nxt_s[0];
            fifo_mem_r[1] <= fifo_mem_nxt_s[1];
            ctrl_r        <= ctrl_nxt_s;
            // Ready and link-up are pre-decoded from next state so they come
            // straight from flops with no path from I_valid.
            ready_r       <= (state_nxt_s == ST_RUN) && (count_nxt_s < 2'd2);
            link_r        <= (state_nxt_s == ST_RUN);
            for (int k = 0; k < 8; k++) begin
                lane_r[k] <= lane_nxt_s[k];
            end
        end
    end

    assign O_ready   = ready_r;
    assign O_link_up = link_r;
    assign o0_p      = lane_r[0];
    assign o1_p      = lane_r[1];
    assign o2_p      = lane_r[2];
    assign o3_p      = lane_r[3];
    assign o4_p      = lane_r[4];
    assign o5_p      = lane_r[5];
    assign o6_p      = lane_r[6];
    assign o7_p      = lane_r[7];
    assign o8_p      = ctrl_r;

endmodule
